// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: owns the PC, drives the imem request
// handshake, and controls the IF/ID latch (write/flush) and the next-PC select.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_pc_src,
    input  logic [31:0] ex_mem_npc,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        pc_sel,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic [15:0] stall_cycles,
    output logic        misalign_err,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);
    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [7:0]  wait_q, wait_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        load_use;
    logic        redirect;
    logic        wait_hit;
    logic [8:0]  wait_next;
    logic [15:0] stall_bump;

    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0)
                      && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // A branch resolved while we are still in IDLE has nothing to redirect.
    assign redirect = ex_mem_pc_src && (state_q != IDLE);

    assign wait_next  = {1'b0, wait_q} + 9'd1;
    assign wait_hit   = (state_q == FETCH) && !imem_ready && (wait_next >= TIMEOUT_W);
    assign stall_bump = (stall_cycles_q == 16'hFFFF) ? stall_cycles_q : stall_cycles_q + 16'd1;

    assign npc      = pc_q + 32'd4;
    assign imem_req = (state_q == FETCH);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        stall_cycles_d = stall_cycles_q;
        wait_d         = wait_q;
        misalign_d     = misalign_q || (redirect && (ex_mem_npc[1:0] != 2'b00));
        timeout_d      = timeout_q || wait_hit;
        pc_sel         = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;

        if (redirect) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            pc_d        = {ex_mem_npc[31:2], 2'b00};
            state_d     = FETCH;
            wait_d      = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (!imem_ready) begin
                        wait_d = wait_hit ? TIMEOUT_8 : wait_next[7:0];
                    end else begin
                        wait_d = 8'd0;
                        if (load_use) begin
                            stall_cycles_d = stall_bump;
                            state_d        = STALL;
                        end else begin
                            if_id_write = 1'b1;
                            pc_d        = npc;
                        end
                    end
                end
                STALL: begin
                    // The memory keeps presenting pc's data, so release needs no ready.
                    if (imem_ready) wait_d = 8'd0;
                    if (load_use) begin
                        stall_cycles_d = stall_bump;
                    end else begin
                        if_id_write = 1'b1;
                        pc_d        = npc;
                        state_d     = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; reset is asynchronous and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            stall_cycles_q <= 16'd0;
            wait_q         <= 8'd0;
            misalign_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            stall_cycles_q <= stall_cycles_d;
            wait_q         <= wait_d;
            misalign_q     <= misalign_d;
            timeout_q      <= timeout_d;
        end
    end

    assign pc            = pc_q;
    assign stall_cycles  = stall_cycles_q;
    assign misalign_err  = misalign_q;
    assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a cycle-level reference model of the fetch rules.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          T      = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_pc_src;
    logic [31:0] ex_mem_npc;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pc_sel;
    logic        if_id_write;
    logic        if_id_flush;
    logic [15:0] stall_cycles;
    logic        misalign_err;
    logic        fetch_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_live;
    bit          m_stall;
    bit          m_mis;
    bit          m_to;
    int          m_stalls;
    int          m_waits;

    // DUT values sampled mid-cycle, for directed checks
    logic [31:0] s_pc, s_npc;
    logic        s_req, s_wr, s_fl, s_sel;

    fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_mem_pc_src  (ex_mem_pc_src),
        .ex_mem_npc     (ex_mem_npc),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .pc             (pc),
        .npc            (npc),
        .pc_sel         (pc_sel),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .stall_cycles   (stall_cycles),
        .misalign_err   (misalign_err),
        .fetch_timeout  (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_live   = 0;
        m_stall  = 0;
        m_mis    = 0;
        m_to     = 0;
        m_stalls = 0;
        m_waits  = 0;
    endtask

    function automatic int bump(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // One clock cycle: sample at the falling edge, compare, then advance the model.
    task automatic cycle();
        logic        hz, e_wr, e_fl, e_sel, e_req;
        logic [31:0] n_pc;
        bit          n_stall, n_mis, n_to;
        int          n_stalls, n_waits;
        @(negedge clk);
        s_pc  = pc;
        s_npc = npc;
        s_req = imem_req;
        s_wr  = if_id_write;
        s_fl  = if_id_flush;
        s_sel = pc_sel;
        hz = id_ex_mem_read && (id_ex_rt != 0) && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
        e_wr = 0; e_fl = 0; e_sel = 0; e_req = 0;
        n_pc = m_pc; n_stall = m_stall; n_mis = m_mis; n_to = m_to;
        n_stalls = m_stalls; n_waits = m_waits;
        if (m_live) begin
            e_req = !m_stall;
            if (!m_stall && !imem_ready && (m_waits + 1 >= T)) n_to = 1;
            if (ex_mem_pc_src) begin
                e_sel   = 1;
                e_fl    = 1;
                n_pc    = ex_mem_npc & 32'hFFFF_FFFC;
                n_stall = 0;
                n_waits = 0;
                if (ex_mem_npc[1:0] != 2'b00) n_mis = 1;
            end else if (!m_stall) begin
                if (!imem_ready) begin
                    n_waits = m_waits + 1;
                end else begin
                    n_waits = 0;
                    if (hz) begin
                        n_stall  = 1;
                        n_stalls = bump(m_stalls);
                    end else begin
                        e_wr = 1;
                        n_pc = m_pc + 32'd4;
                    end
                end
            end else begin
                if (imem_ready) n_waits = 0;
                if (hz) begin
                    n_stalls = bump(m_stalls);
                end else begin
                    e_wr    = 1;
                    n_pc    = m_pc + 32'd4;
                    n_stall = 0;
                end
            end
        end
        check("pc", s_pc, m_pc);
        check("npc", s_npc, m_pc + 32'd4);
        check("imem_req", 32'(s_req), 32'(e_req));
        check("pc_sel", 32'(s_sel), 32'(e_sel));
        check("if_id_write", 32'(s_wr), 32'(e_wr));
        check("if_id_flush", 32'(s_fl), 32'(e_fl));
        check("write_flush_excl", 32'(s_wr & s_fl), 32'd0);
        check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
        check("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
        @(posedge clk);
        #1;
        m_pc = n_pc; m_live = 1; m_stall = n_stall; m_mis = n_mis; m_to = n_to;
        m_stalls = n_stalls; m_waits = n_waits;
    endtask

    task automatic random_cycles(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            imem_ready     = ($urandom_range(0, 99) < ready_pct);
            id_ex_mem_read = ($urandom_range(0, 99) < 30);
            id_ex_rt       = 5'($urandom_range(0, 3));
            if_id_rs       = 5'($urandom_range(0, 3));
            if_id_rt       = 5'($urandom_range(0, 3));
            ex_mem_pc_src  = ($urandom_range(0, 99) < 5);
            ex_mem_npc     = $urandom;
            if ($urandom_range(0, 3) != 0) ex_mem_npc[1:0] = 2'b00;
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ex_mem_pc_src = 0; ex_mem_npc = 0; id_ex_mem_read = 0;
        id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0; imem_ready = 1;
        model_reset();
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_req", 32'(imem_req), 0);
        check("rst_stalls", 32'(stall_cycles), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE for one cycle, then sequential fetch
        cycle();
        check("idle_req", 32'(s_req), 0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("seq_pc", s_pc, 32'(4 * k));
            check("seq_write", 32'(s_wr), 1);
        end

        // Load-use at pc=8 for two cycles
        id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5;
        cycle();
        check("lu_pc_a", s_pc, 32'h8);
        check("lu_write_a", 32'(s_wr), 0);
        cycle();
        check("lu_pc_b", s_pc, 32'h8);
        check("lu_write_b", 32'(s_wr), 0);
        id_ex_mem_read = 0;
        check("lu_count", 32'(stall_cycles), 2);
        cycle();
        check("lu_release_write", 32'(s_wr), 1);
        check("lu_after_pc", pc, 32'hC);

        // Same stimulus with rt=0 is not a hazard
        id_ex_mem_read = 1; id_ex_rt = 0;
        cycle();
        check("rt0_write", 32'(s_wr), 1);
        cycle();
        check("rt0_pc", pc, 32'h14);
        check("rt0_count", 32'(stall_cycles), 2);

        // Redirect during a stall
        id_ex_rt = 5;
        cycle();
        ex_mem_pc_src = 1; ex_mem_npc = 32'h40;
        cycle();
        check("redir_sel", 32'(s_sel), 1);
        check("redir_flush", 32'(s_fl), 1);
        check("redir_write", 32'(s_wr), 0);
        check("redir_pc", pc, 32'h40);
        check("redir_count", 32'(stall_cycles), 3);
        ex_mem_pc_src = 0; id_ex_mem_read = 0;
        cycle();
        check("redir_fetch", 32'(s_req), 1);

        // Misaligned redirect
        ex_mem_pc_src = 1; ex_mem_npc = 32'h43;
        cycle();
        ex_mem_pc_src = 0;
        check("mis_pc", pc, 32'h40);
        check("mis_flag", 32'(misalign_err), 1);
        for (int k = 0; k < 10; k++) cycle();
        check("mis_sticky", 32'(misalign_err), 1);

        // Timeout after T ready-less cycles
        imem_ready = 0;
        for (int k = 0; k < T - 1; k++) cycle();
        check("to_early", 32'(fetch_timeout), 0);
        cycle();
        check("to_flag", 32'(fetch_timeout), 1);
        check("to_pc_held", pc, 32'h68);
        imem_ready = 1;
        cycle();
        check("to_pc_adv", pc, 32'h6C);
        check("to_sticky", 32'(fetch_timeout), 1);

        // PC wrap at the top of the address space
        ex_mem_pc_src = 1; ex_mem_npc = 32'hFFFF_FFFC;
        cycle();
        ex_mem_pc_src = 0;
        cycle();
        check("wrap_npc", s_npc, 32'h0);
        check("wrap_pc", pc, 32'h0);

        // Asynchronous reset in the middle of a stall
        ex_mem_pc_src = 1; ex_mem_npc = 32'h20;
        cycle();
        ex_mem_pc_src = 0; id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5;
        cycle();
        check("mid_pc", pc, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", pc, RST_PC);
        check("arst_req", 32'(imem_req), 0);
        check("arst_write", 32'(if_id_write), 0);
        check("arst_flush", 32'(if_id_flush), 0);
        check("arst_sel", 32'(pc_sel), 0);
        check("arst_stalls", 32'(stall_cycles), 0);
        check("arst_mis", 32'(misalign_err), 0);
        check("arst_to", 32'(fetch_timeout), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_ex_mem_read = 0;
        cycle();
        check("arst_idle", 32'(s_req), 0);
        cycle();
        check("arst_fetch", 32'(s_req), 1);
        check("arst_first_pc", s_pc, RST_PC);

        // Random traffic: mostly-ready memory, then a slow one
        random_cycles(1500, 90);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        random_cycles(1500, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch stage. It owns the program counter and drives the instruction-memory request handshake. It also generates the IF/ID latch write-enable and flush, and selects between the sequential PC and the EX/MEM branch target. It sits between the fetch datapath (PC mux, incrementer, instruction memory, IF/ID latch) and the downstream hazard and branch signals.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, imem_ready wait cycles before fetch_timeout asserts (range 2..255)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_mem_pc_src  input  1  branch/jump taken, resolved in EX/MEM
ex_mem_npc  input  32  branch/jump target
id_ex_mem_read  input  1  instruction in ID/EX is a load
id_ex_rt  input  5  load destination register
if_id_rs  input  5  source register rs of the instruction in IF/ID
if_id_rt  input  5  source register rt of the instruction in IF/ID
imem_ready  input  1  instruction memory data valid for current pc
imem_req  output  1  fetch request for address pc
pc  output  32  current fetch address (registered)
npc  output  32  pc + 4, combinational
pc_sel  output  1  1 = next PC from ex_mem_npc, 0 = npc
if_id_write  output  1  IF/ID latch load enable
if_id_flush  output  1  IF/ID latch clear (insert bubble)
stall_cycles  output  16  saturating count of load-use stall cycles
misalign_err  output  1  sticky: redirect target had nonzero bits [1:0]
fetch_timeout  output  1  sticky: imem_ready absent for TIMEOUT cycles

Behaviour:
- Reset (async, any cycle, including mid-fetch):
  - pc=RESET_PC, state=IDLE.
  - imem_req, if_id_write, if_id_flush, pc_sel, misalign_err, fetch_timeout = 0; stall_cycles=0; wait counter=0.
- States: IDLE, FETCH, STALL.
  - IDLE: all strobes 0; unconditionally -> FETCH on the next edge. The first request is therefore 1 cycle after reset release.
- Hazard: load_use = id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
- Redirect (ex_mem_pc_src=1 in FETCH or STALL) has highest priority:
  - Same cycle: pc_sel=1, if_id_flush=1, if_id_write=0.
  - Next edge: pc <= {ex_mem_npc[31:2],2'b00}; state -> FETCH; wait counter cleared.
  - The in-flight fetch result is discarded.
  - In IDLE, ex_mem_pc_src is ignored and pc_sel stays 0.
- FETCH: imem_req=1.
  - imem_ready=1 and !load_use: if_id_write=1; pc <= npc at the edge; stay in FETCH. This gives 1 instruction per cycle with a zero-wait memory.
  - imem_ready=1 and load_use: if_id_write=0, if_id_flush=0; pc held; -> STALL.
  - imem_ready=0: pc held, if_id_write=0; wait counter increments.
- STALL: imem_req=0; pc held. Instruction memory output stays valid while pc is unchanged.
  - Each STALL cycle increments stall_cycles, saturating at 16'hFFFF. The FETCH cycle that detects the hazard also counts.
  - When load_use drops: if_id_write=1, pc <= npc, -> FETCH.
- Wait counter (8-bit): cleared on any imem_ready=1 or redirect. When it reaches TIMEOUT, fetch_timeout=1 (sticky until reset); fetching continues.
- misalign_err: set on a redirect with ex_mem_npc[1:0]!=0; sticky until reset.
- Width rules: npc = pc + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0 without a flag.
- Simultaneous events:
  - Redirect + load_use: redirect wins, no stall count.
  - Redirect + imem_ready: flush, no IF/ID write.
  - Redirect in the same cycle as the timeout threshold: counter clears; flag still sets if the threshold was hit that cycle.
- Invariant: if_id_write and if_id_flush are never both 1.

Test Plan:
- Reset then imem_ready tied 1, no hazards -> IDLE 1 cycle; pc sequence 0,4,8,12; if_id_write=1 every FETCH cycle.
- Load-use: at pc=8, id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 for 2 cycles -> pc stays 8 for 2 cycles; if_id_write=0 for those 2 cycles; stall_cycles=2; then pc=12. Same stimulus with id_ex_rt=0 -> no stall.
- Redirect: ex_mem_pc_src=1, ex_mem_npc=32'h40 during a stall -> same cycle pc_sel=1, if_id_flush=1; next pc=32'h40; state FETCH; stall_cycles unchanged.
- Misaligned redirect to 32'h43 -> pc=32'h40, misalign_err=1, still 1 after 10 further cycles.
- imem_ready held 0 for 16 cycles (TIMEOUT=16) -> fetch_timeout=1, pc unchanged; ready=1 -> pc advances by 4 and the flag stays set.
- Assert rst_n low mid-stall with pc=32'h20 -> pc=RESET_PC immediately (before the next clock edge); all strobes and counters 0; after release, IDLE then FETCH.
